// File: rtl/sram_pri_data_ctrl.sv
// Initiator-side controller for the private data SRAM port: request stream in,
// read data out through a credit-limited response FIFO, optional zero-fill after reset.
module sram_pri_data_ctrl #(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 128,
    parameter int RSP_DEPTH     = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [15:0]           req_be,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_busy,
    output logic                  SRAM_CEN,
    output logic                  SRAM_WEN,
    output logic [15:0]           SRAM_BEN,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                r_state;
    logic                  r_initBusy;
    logic [ADDR_WIDTH-1:0] r_initAddr;
    logic [CW-1:0]         r_cnt;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_fifoMem [RSP_DEPTH];
    logic [PW-1:0]         r_wrPtr;
    logic [PW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_fifoCnt;

    logic w_rspValid;
    logic w_pop;
    logic w_reqReady;
    logic w_fire;
    logic w_readFire;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reset forces the handshake and SRAM pins idle in the same cycle it is seen.
    assign w_rspValid = !RST && (r_fifoCnt != '0);
    assign w_pop      = w_rspValid && rsp_ready;
    assign w_reqReady = !RST && (r_state == ST_RUN) && ((r_cnt < CW'(RSP_DEPTH)) || w_pop);
    assign w_fire     = req_valid && w_reqReady;
    assign w_readFire = w_fire && !req_we;

    assign req_ready = w_reqReady;
    assign rsp_valid = w_rspValid;
    assign rsp_rdata = r_fifoMem[r_rdPtr];
    assign init_busy = r_initBusy;

    always_comb begin
        SRAM_CEN = 1'b1;
        SRAM_WEN = 1'b1;
        SRAM_BEN = '1;
        SRAM_A   = '0;
        SRAM_D   = '0;
        if (!RST && (r_state == ST_INIT)) begin
            SRAM_CEN = 1'b0;
            SRAM_WEN = 1'b0;
            SRAM_BEN = '0;
            SRAM_A   = r_initAddr;
        end else if (w_fire) begin
            // A write with no byte enables is consumed without touching the macro.
            SRAM_CEN = req_we && (req_be == '0);
            SRAM_WEN = ~req_we;
            SRAM_BEN = req_we ? ~req_be : '0;
            SRAM_A   = req_addr;
            SRAM_D   = req_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            r_initBusy <= INIT_ON_RESET;
            r_initAddr <= '0;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_fifoCnt  <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_initAddr <= r_initAddr + 1'b1;
                if (r_initAddr == ADDR_WIDTH'(DEPTH - 1)) begin
                    r_state    <= ST_RUN;
                    r_initBusy <= 1'b0;
                end
            end
            r_inflight <= w_readFire;
            // cnt covers the read in flight plus FIFO occupancy, so a push always has room.
            r_cnt      <= r_cnt + CW'(w_readFire) - CW'(w_pop);
            if (r_inflight) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            r_fifoCnt <= r_fifoCnt + CW'(r_inflight) - CW'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && r_inflight) begin
            r_fifoMem[r_wrPtr] <= SRAM_Q;
        end
    end

endmodule

// File: tb/tb_sram_pri_data_ctrl.sv
// Bench for sram_pri_data_ctrl: SRAM macro model, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_sram_pri_data_ctrl;

    localparam int AW        = 4;
    localparam int DW        = 128;
    localparam int RSP_DEPTH = 2;
    localparam int DEPTH     = 16;

    logic          CLK;
    logic          rst;
    logic          reqValid;
    logic          reqReady;
    logic          reqWe;
    logic [15:0]   reqBe;
    logic [AW-1:0] reqAddr;
    logic [DW-1:0] reqWdata;
    logic          rspValid;
    logic          rspReady;
    logic [DW-1:0] rspRdata;
    logic          initBusy;
    logic          sramCen;
    logic          sramWen;
    logic [15:0]   sramBen;
    logic [AW-1:0] sramA;
    logic [DW-1:0] sramD;
    logic [DW-1:0] sramQ;

    int checkCount = 0;
    int failCount  = 0;

    logic [DW-1:0] sramMem [DEPTH];

    logic [DW-1:0] refMem [DEPTH];
    logic [DW-1:0] rspQ [$];
    int            rspT [$];
    logic          modelInit;
    int            modelIdx;
    int            cyc;

    localparam logic [DW-1:0] WORD3 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [DW-1:0] WORD1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [DW-1:0] WORD2 = 128'h2222_BBBB_CCCC_DDDD_EEEE_FFFF_0000_9999;

    sram_pri_data_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RSP_DEPTH(RSP_DEPTH),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(rst),
        .req_valid(reqValid),
        .req_ready(reqReady),
        .req_we(reqWe),
        .req_be(reqBe),
        .req_addr(reqAddr),
        .req_wdata(reqWdata),
        .rsp_valid(rspValid),
        .rsp_ready(rspReady),
        .rsp_rdata(rspRdata),
        .init_busy(initBusy),
        .SRAM_CEN(sramCen),
        .SRAM_WEN(sramWen),
        .SRAM_BEN(sramBen),
        .SRAM_A(sramA),
        .SRAM_D(sramD),
        .SRAM_Q(sramQ)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Macro model with garbage power-up contents so the zero-fill is observable.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sramMem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    always @(posedge CLK) begin
        if (!sramCen) begin
            if (!sramWen) begin
                for (int b = 0; b < 16; b++) begin
                    if (!sramBen[b]) sramMem[sramA][8*b +: 8] <= sramD[8*b +: 8];
                end
            end else begin
                sramQ <= sramMem[sramA];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model: memory image plus a queue of pending responses, each visible
    // from two cycles after its read was accepted; evaluated mid-cycle on every cycle.
    initial begin
        logic          expValid;
        logic          expReady;
        logic          fire;
        logic          expCen;
        logic          expWen;
        logic [15:0]   expBen;
        logic [AW-1:0] expA;
        logic [DW-1:0] expD;
        modelInit = 1'b1;
        modelIdx  = 0;
        cyc       = 0;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            cyc++;
            expCen = 1'b1; expWen = 1'b1; expBen = '1; expA = '0; expD = '0;
            expValid = 1'b0; expReady = 1'b0; fire = 1'b0;
            if (!rst && modelInit) begin
                expCen = 1'b0; expWen = 1'b0; expBen = '0; expA = modelIdx[AW-1:0];
            end else if (!rst) begin
                expValid = (rspQ.size() > 0) && (rspT[0] <= cyc);
                expReady = (rspQ.size() < RSP_DEPTH) || (expValid && rspReady);
                fire     = reqValid && expReady;
                if (fire) begin
                    expCen = reqWe && (reqBe == 16'h0);
                    expWen = !reqWe;
                    expBen = reqWe ? ~reqBe : 16'h0;
                    expA   = reqAddr;
                    expD   = reqWdata;
                end
            end
            checkOutput("initBusy", initBusy, modelInit);
            checkOutput("reqReady", reqReady, expReady);
            checkOutput("rspValid", rspValid, expValid);
            if (expValid) checkOutput("rspRdata", rspRdata, rspQ[0]);
            checkOutput("sramCen", sramCen, expCen);
            checkOutput("sramWen", sramWen, expWen);
            checkOutput("sramBen", sramBen, expBen);
            checkOutput("sramA", sramA, expA);
            checkOutput("sramD", sramD, expD);
            if (rst) begin
                rspQ.delete();
                rspT.delete();
                modelInit = 1'b1;
                modelIdx  = 0;
            end else if (modelInit) begin
                refMem[modelIdx] = '0;
                modelIdx++;
                if (modelIdx == DEPTH) modelInit = 1'b0;
            end else begin
                if (expValid && rspReady) begin
                    rspQ.delete(0);
                    rspT.delete(0);
                end
                if (fire && reqWe) begin
                    for (int b = 0; b < 16; b++) begin
                        if (reqBe[b]) refMem[reqAddr][8*b +: 8] = reqWdata[8*b +: 8];
                    end
                end else if (fire) begin
                    rspQ.push_back(refMem[reqAddr]);
                    rspT.push_back(cyc + 2);
                end
            end
        end
    end

    // Drives one cycle of inputs just after the edge and returns mid-cycle.
    task automatic applyStimulus(input logic r, input logic v, input logic we, input logic [15:0] be,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
        @(posedge CLK);
        #1;
        rst = r; reqValid = v; reqWe = we; reqBe = be; reqAddr = a; reqWdata = d; rspReady = rr;
        #3;
    endtask

    task automatic idle(input logic rr);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, '0, '0, rr);
    endtask

    task automatic countInit(input string name);
        int  n = 0;
        logic sawReady = 1'b0;
        for (int k = 0; k < 40; k++) begin
            idle(1'b1);
            if (k == 0) checkOutput({name, "FirstAddr"}, sramA, 0);
            if (!initBusy) break;
            n++;
            if (reqReady) sawReady = 1'b1;
        end
        checkOutput({name, "Cycles"}, n, 16);
        checkOutput({name, "NoReady"}, sawReady, 1'b0);
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [15:0] be, input logic [DW-1:0] d, input string name);
        applyStimulus(1'b0, 1'b1, 1'b1, be, a, d, 1'b1);
        checkOutput({name, "Ready"}, reqReady, 1'b1);
    endtask

    task automatic doRead(input logic [AW-1:0] a, input logic [DW-1:0] expData, input string name);
        int   lat = 0;
        logic got = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, a, '0, 1'b1);
        checkOutput({name, "Ready"}, reqReady, 1'b1);
        for (int k = 0; k < 8; k++) begin
            idle(1'b1);
            lat++;
            if (rspValid) begin
                checkOutput({name, "Data"}, rspRdata, expData);
                got = 1'b1;
                break;
            end
        end
        checkOutput({name, "Latency"}, got ? lat : 99, 2);
    endtask

    initial begin
        int   readyCnt;
        int   rspCnt;
        logic stale;
        logic [15:0] be;
        rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqBe = '0; reqAddr = '0; reqWdata = '0; rspReady = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, '0, '0, 1'b0);
        checkOutput("resetCen", sramCen, 1'b1);
        checkOutput("resetBusy", initBusy, 1'b1);

        $display("[TB] zero-fill after reset");
        countInit("init");
        doRead(4'd7, '0, "rd7");

        $display("[TB] write then read back");
        doWrite(4'd3, 16'hFFFF, WORD3, "wr3");
        doRead(4'd3, WORD3, "rd3");

        $display("[TB] partial write");
        doWrite(4'd5, 16'h0001, '1, "wr5");
        checkOutput("partialBen", sramBen, 16'hFFFE);
        doRead(4'd5, 128'hFF, "rd5");

        $display("[TB] write with no byte enables");
        doWrite(4'd9, 16'h0000, WORD1, "wrBe0");
        checkOutput("be0Cen", sramCen, 1'b1);
        doRead(4'd9, '0, "rd9");

        $display("[TB] response backpressure");
        doWrite(4'd1, 16'hFFFF, WORD1, "wr1");
        doWrite(4'd2, 16'hFFFF, WORD2, "wr2");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'd1, '0, 1'b0);
        checkOutput("bpRead1Ready", reqReady, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'd2, '0, 1'b0);
        checkOutput("bpRead2Ready", reqReady, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'd3, '0, 1'b0);
        checkOutput("bpRead3Blocked", reqReady, 1'b0);
        checkOutput("bpHeadData", rspRdata, WORD1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'd3, '0, 1'b0);
        checkOutput("bpStillBlocked", reqReady, 1'b0);
        checkOutput("bpHoldValid", rspValid, 1'b1);
        checkOutput("bpHoldData", rspRdata, WORD1);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'd3, '0, 1'b1);
        checkOutput("bpFireOnPop", reqReady, 1'b1);
        checkOutput("bpPop1", rspRdata, WORD1);
        idle(1'b1);
        checkOutput("bpPop2Valid", rspValid, 1'b1);
        checkOutput("bpPop2", rspRdata, WORD2);
        idle(1'b1);
        checkOutput("bpPop3Valid", rspValid, 1'b1);
        checkOutput("bpPop3", rspRdata, WORD3);
        idle(1'b1);

        $display("[TB] back-to-back reads");
        readyCnt = 0;
        rspCnt   = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'(i), '0, 1'b1);
            if (reqReady) readyCnt++;
            if (rspValid) rspCnt++;
        end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (rspValid) rspCnt++;
        end
        checkOutput("tputReady", readyCnt, 16);
        checkOutput("tputRsp", rspCnt, 16);

        $display("[TB] reset with a read in flight and one queued");
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'd1, '0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 4'd2, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, '0, '0, 1'b0);
        checkOutput("rstRspValid", rspValid, 1'b0);
        countInit("reinit");
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (rspValid) stale = 1'b1;
        end
        checkOutput("noStaleRsp", stale, 1'b0);
        doRead(4'd3, '0, "rdAfterReinit");

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0: be = 16'h0000;
                1: be = 16'hFFFF;
                default: be = 16'($urandom);
            endcase
            applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                          be, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
                          $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 24; i++) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
